mem_branch_unit: RTL and testbench

- MEM-stage branch resolution unit with an integrated bimodal branch history table (BHT) of 2-bit saturating counters.
- Fetch queries the BHT combinationally for a taken/not-taken prediction.
- MEM resolves full RV32 branch conditions from ALU flags, compares the outcome against the carried prediction, and emits a registered redirect/flush one cycle later.
- Trains the BHT on every resolved conditional branch.

---
 rtl/riscv_cpu_pkg.sv | 54 +++++
 rtl/branch_bht.sv | 60 ++++++
 rtl/mem_branch_unit.sv | 127 ++++++++++++
 tb/tb_mem_branch_unit.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_cpu_pkg.sv
// ---------------------------------------------------------------------------
// riscv_cpu_pkg
// Shared types for the RV32 pipeline slice:
//   - ALU flag vector layout (CSR_ZERO / CSR_SIGN / CSR_OVF / CSR_CARRY)
//   - branch_op_e encoding carried down the pipe to MEM
//   - helpers to classify a branch op and evaluate its condition
// CSR_CARRY is the unsigned borrow of a - b, i.e. set when a < b unsigned.
// ---------------------------------------------------------------------------
package riscv_cpu_pkg;

    localparam int CSR_WIDTH = 4;
    localparam int CSR_ZERO  = 0;
    localparam int CSR_SIGN  = 1;
    localparam int CSR_OVF   = 2;
    localparam int CSR_CARRY = 3;

    typedef enum logic [2:0] {
        BR_NONE   = 3'd0,
        BR_EQ     = 3'd1,
        BR_NE     = 3'd2,
        BR_LT     = 3'd3,
        BR_GE     = 3'd4,
        BR_LTU    = 3'd5,
        BR_GEU    = 3'd6,
        BR_ALWAYS = 3'd7
    } branch_op_e;

    // Only real conditional branches train the predictor; jumps and
    // non-branches would only pollute the counters.
    function automatic logic is_cond_branch(branch_op_e op);
        return (op != BR_NONE) && (op != BR_ALWAYS);
    endfunction

    function automatic logic branch_condition(branch_op_e op,
                                              logic [CSR_WIDTH-1:0] csr);
        logic z, s, v, c;
        z = csr[CSR_ZERO];
        s = csr[CSR_SIGN];
        v = csr[CSR_OVF];
        c = csr[CSR_CARRY];
        case (op)
            BR_NONE:   return 1'b0;
            BR_EQ:     return z;
            BR_NE:     return ~z;
            BR_LT:     return s ^ v;
            BR_GE:     return ~(s ^ v);
            BR_LTU:    return c;
            BR_GEU:    return ~c;
            BR_ALWAYS: return 1'b1;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/branch_bht.sv
// ---------------------------------------------------------------------------
// branch_bht
// Bimodal branch history table of CNT_W-bit saturating counters.
//   clk_i       clock
//   rst_ni      asynchronous active-low reset (all counters -> weakly NT)
//   rd_idx_i    combinational read index (fetch lookup)
//   rd_taken_o  MSB of the indexed counter
//   wr_en_i     train the entry at wr_idx_i this edge
//   wr_idx_i    training index
//   wr_taken_i  resolved outcome: 1 = increment, 0 = decrement (saturating)
// The read path sees the pre-update value on a same-index read/write cycle.
// ---------------------------------------------------------------------------
module branch_bht #(
    parameter int BHT_DEPTH = 64,
    parameter int CNT_W     = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [$clog2(BHT_DEPTH)-1:0] rd_idx_i,
    output logic                         rd_taken_o,
    input  logic                         wr_en_i,
    input  logic [$clog2(BHT_DEPTH)-1:0] wr_idx_i,
    input  logic                         wr_taken_i
);

    localparam int IDX_W = $clog2(BHT_DEPTH);
    // Weakly not-taken: 2^(CNT_W-1)-1, which collapses to 0 for CNT_W = 1.
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [BHT_DEPTH-1:0][CNT_W-1:0] cnt_all;

    // Counters need a reset value, so the table is a register file of
    // per-entry flops rather than a RAM.
    generate
        for (genvar gi = 0; gi < BHT_DEPTH; gi++) begin : gen_entry
            logic [CNT_W-1:0] cnt_reg;
            logic             hit;

            assign hit = wr_en_i && (wr_idx_i == IDX_W'(gi));

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    cnt_reg <= CNT_INIT;
                end else if (hit) begin
                    if (wr_taken_i && (cnt_reg != CNT_MAX)) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end else if (!wr_taken_i && (cnt_reg != '0)) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
            end

            assign cnt_all[gi] = cnt_reg;
        end
    endgenerate

    assign rd_taken_o = cnt_all[rd_idx_i][CNT_W-1];

endmodule

// File: rtl/mem_branch_unit.sv
// ---------------------------------------------------------------------------
// mem_branch_unit
// MEM-stage branch resolution with an integrated bimodal predictor.
//   clk_i / rst_ni          clock, asynchronous active-low reset
//   fetch_pc_i              PC being fetched; predict_taken_o is its
//                           combinational prediction
//   valid_i / stall_i       a resolution fires when valid and not stalled
//   pc_i / target_i         MEM instruction PC and computed target
//   csr_i / branch_op_i     ALU flags and branch operation
//   pred_taken_i            prediction that travelled with the instruction
//   resolve_valid_o, taken_o, mispredict_o, redirect_pc_o
//                           registered result, one cycle after fire
//   branch_count_o, mispredict_count_o
//                           performance counters, present only when the
//                           BRANCH_PERF_EN macro is defined (else tied to 0)
// ---------------------------------------------------------------------------
module mem_branch_unit
    import riscv_cpu_pkg::*;
#(
    parameter int BHT_DEPTH = 64,
    parameter int CNT_W     = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [31:0]          fetch_pc_i,
    output logic                 predict_taken_o,
    input  logic                 valid_i,
    input  logic                 stall_i,
    input  logic [31:0]          pc_i,
    input  logic [31:0]          target_i,
    input  logic [CSR_WIDTH-1:0] csr_i,
    input  logic [2:0]           branch_op_i,
    input  logic                 pred_taken_i,
    output logic                 resolve_valid_o,
    output logic                 taken_o,
    output logic                 mispredict_o,
    output logic [31:0]          redirect_pc_o,
    output logic [31:0]          branch_count_o,
    output logic [31:0]          mispredict_count_o
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    branch_op_e  op;
    logic        fire;
    logic        cond;
    logic        mispredict_next;
    logic [31:0] redirect_next;

    logic        resolve_valid_reg;
    logic        taken_reg;
    logic        mispredict_reg;
    logic [31:0] redirect_pc_reg;

    // Only the index bits of the fetch PC feed the table.
    logic unused_fetch_bits;
    assign unused_fetch_bits = ^{fetch_pc_i[31:IDX_W+2], fetch_pc_i[1:0]};

    assign op              = branch_op_e'(branch_op_i);
    assign fire            = valid_i && !stall_i;
    assign cond            = branch_condition(op, csr_i);
    // A BR_NONE predicted taken (alias hit in fetch) also mispredicts and
    // falls through to pc + 4.
    assign mispredict_next = (cond != pred_taken_i);
    assign redirect_next   = cond ? target_i : (pc_i + 32'd4);

    branch_bht #(
        .BHT_DEPTH (BHT_DEPTH),
        .CNT_W     (CNT_W)
    ) u_bht (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .rd_idx_i   (fetch_pc_i[IDX_W+1:2]),
        .rd_taken_o (predict_taken_o),
        .wr_en_i    (fire && is_cond_branch(op)),
        .wr_idx_i   (pc_i[IDX_W+1:2]),
        .wr_taken_i (cond)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resolve_valid_reg <= 1'b0;
            taken_reg         <= 1'b0;
            mispredict_reg    <= 1'b0;
            redirect_pc_reg   <= 32'd0;
        end else begin
            resolve_valid_reg <= fire;
            taken_reg         <= fire && cond;
            mispredict_reg    <= fire && mispredict_next;
            // Redirect target is held between resolutions.
            if (fire) begin
                redirect_pc_reg <= redirect_next;
            end
        end
    end

    assign resolve_valid_o = resolve_valid_reg;
    assign taken_o         = taken_reg;
    assign mispredict_o    = mispredict_reg;
    assign redirect_pc_o   = redirect_pc_reg;

`ifdef BRANCH_PERF_EN
    logic [31:0] branch_count_reg;
    logic [31:0] mispredict_count_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            branch_count_reg     <= 32'd0;
            mispredict_count_reg <= 32'd0;
        end else if (fire) begin
            if ((op != BR_NONE) && (branch_count_reg != 32'hFFFF_FFFF)) begin
                branch_count_reg <= branch_count_reg + 32'd1;
            end
            if (mispredict_next && (mispredict_count_reg != 32'hFFFF_FFFF)) begin
                mispredict_count_reg <= mispredict_count_reg + 32'd1;
            end
        end
    end

    assign branch_count_o     = branch_count_reg;
    assign mispredict_count_o = mispredict_count_reg;
`else
    assign branch_count_o     = 32'd0;
    assign mispredict_count_o = 32'd0;
`endif

endmodule

// File: tb/tb_mem_branch_unit.sv
module tb_mem_branch_unit;
    import riscv_cpu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] fetch_pc;
    logic        predict_taken;
    logic        valid;
    logic        stall;
    logic [31:0] pc;
    logic [31:0] target;
    logic [3:0]  csr;
    logic [2:0]  branch_op;
    logic        pred_taken;
    logic        resolve_valid;
    logic        taken;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int checks   = 0;
    int failures = 0;

    // Reference model: table of integer counters plus expected outputs.
    int          bht_m [64];
    int          exp_bc;
    int          exp_mc;
    logic        exp_valid;
    logic        exp_taken;
    logic        exp_misp;
    logic [31:0] exp_redir;
    logic [31:0] op_a;
    logic [31:0] op_b;

    mem_branch_unit dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .fetch_pc_i         (fetch_pc),
        .predict_taken_o    (predict_taken),
        .valid_i            (valid),
        .stall_i            (stall),
        .pc_i               (pc),
        .target_i           (target),
        .csr_i              (csr),
        .branch_op_i        (branch_op),
        .pred_taken_i       (pred_taken),
        .resolve_valid_o    (resolve_valid),
        .taken_o            (taken),
        .mispredict_o       (mispredict),
        .redirect_pc_o      (redirect_pc),
        .branch_count_o     (branch_count),
        .mispredict_count_o (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic model_pred(logic [31:0] p);
        return bht_m[p[7:2]] >= 2;
    endfunction

    // Branch outcome from the source operands, not from the flags.
    function automatic logic model_outcome(logic [2:0] o, logic [31:0] a, logic [31:0] b);
        case (o)
            3'd1:    return a == b;
            3'd2:    return a != b;
            3'd3:    return $signed(a) < $signed(b);
            3'd4:    return $signed(a) >= $signed(b);
            3'd5:    return a < b;
            3'd6:    return a >= b;
            3'd7:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) bht_m[i] = 1;
        exp_bc = 0; exp_mc = 0;
        exp_valid = 0; exp_taken = 0; exp_misp = 0; exp_redir = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        logic out;
        if (valid && !stall) begin
            out       = model_outcome(branch_op, op_a, op_b);
            exp_valid = 1;
            exp_taken = out;
            exp_misp  = (out != pred_taken);
            exp_redir = out ? target : pc + 32'd4;
            if (branch_op != 3'd0 && branch_op != 3'd7) begin
                if (out && bht_m[pc[7:2]] < 3) bht_m[pc[7:2]]++;
                if (!out && bht_m[pc[7:2]] > 0) bht_m[pc[7:2]]--;
            end
`ifdef BRANCH_PERF_EN
            if (branch_op != 3'd0) exp_bc++;
            if (out != pred_taken) exp_mc++;
`endif
        end else begin
            exp_valid = 0; exp_taken = 0; exp_misp = 0;
        end
    endtask

    // Apply one MEM-stage instruction at the falling edge; flags come from a - b.
    task automatic drive(input logic v, input logic s, input logic [31:0] p,
                         input logic [31:0] t, input branch_op_e o,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic pr, input logic [31:0] fp);
        logic [31:0] diff;
        @(negedge clk);
        diff = a - b;
        op_a = a; op_b = b;
        valid = v; stall = s; pc = p; target = t; branch_op = o;
        pred_taken = pr; fetch_pc = fp;
        csr[CSR_ZERO]  = (diff == 32'd0);
        csr[CSR_SIGN]  = diff[31];
        csr[CSR_OVF]   = (a[31] != b[31]) && (diff[31] != a[31]);
        csr[CSR_CARRY] = (a < b);
    endtask

    task automatic test_reset();
        rst_n = 0;
        drive(0, 0, 0, 0, BR_NONE, 0, 0, 0, 32'h100);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
        checks++;
        if (predict_taken !== 1'b0) begin
            failures++; $display("FAIL reset_predict got=%0b want=0", predict_taken);
        end
        checks++;
        if ({resolve_valid, taken, mispredict} !== 3'b000 || redirect_pc !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs got v=%0b t=%0b m=%0b pc=%h want 0", resolve_valid, taken, mispredict, redirect_pc);
        end
        checks++;
        if (branch_count !== 32'd0 || mispredict_count !== 32'd0) begin
            failures++; $display("FAIL reset_counts got=%0d/%0d want=0/0", branch_count, mispredict_count);
        end
    endtask

    task automatic test_directed();
        // Taken BR_EQ, predicted not taken: counter 01 -> 10.
        drive(1, 0, 32'h200, 32'h180, BR_EQ, 5, 5, 0, 32'h200);
        #1; model_step(); @(posedge clk); #1;
        checks++;
        if ({resolve_valid, taken, mispredict} !== 3'b111 || redirect_pc !== 32'h180) begin
            failures++;
            $display("FAIL eq_taken got v=%0b t=%0b m=%0b pc=%h want 1 1 1 00000180", resolve_valid, taken, mispredict, redirect_pc);
        end
        checks++;
        if (predict_taken !== 1'b1) begin
            failures++; $display("FAIL eq_train got=%0b want=1", predict_taken);
        end
        $display("txn eq_taken pc=00000200 taken=%0b misp=%0b", taken, mispredict);
        // Three more taken: saturate at 11.
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 32'h200, 32'h180, BR_EQ, 7, 7, 1, 32'h200);
            #1; model_step(); @(posedge clk); #1;
            checks++;
            if (taken !== 1'b1 || mispredict !== 1'b0) begin
                failures++; $display("FAIL eq_repeat%0d got t=%0b m=%0b want 1 0", i, taken, mispredict);
            end
            $display("txn eq_repeat pc=00000200 taken=%0b misp=%0b", taken, mispredict);
        end
        // One not-taken: 11 -> 10, still predicts taken.
        drive(1, 0, 32'h200, 32'h180, BR_EQ, 7, 8, 1, 32'h200);
        #1; model_step(); @(posedge clk); #1;
        checks++;
        if (taken !== 1'b0 || mispredict !== 1'b1 || redirect_pc !== 32'h204 || predict_taken !== 1'b1) begin
            failures++;
            $display("FAIL eq_sat_nt got t=%0b m=%0b pc=%h p=%0b want 0 1 00000204 1", taken, mispredict, redirect_pc, predict_taken);
        end
        $display("txn eq_not_taken pc=00000200 taken=%0b misp=%0b", taken, mispredict);
        // Second not-taken: 10 -> 01, prediction flips.
        drive(1, 0, 32'h200, 32'h180, BR_EQ, 7, 8, 1, 32'h200);
        #1; model_step(); @(posedge clk); #1;
        checks++;
        if (predict_taken !== 1'b0) begin
            failures++; $display("FAIL eq_decay got=%0b want=0", predict_taken);
        end
        // BR_LT with S=1, V=1 (signed a > b): not taken, pc+4 wraps to 0.
        drive(1, 0, 32'hFFFF_FFFC, 32'h1000, BR_LT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFC);
        #1; model_step(); @(posedge clk); #1;
        checks++;
        if ({resolve_valid, taken, mispredict} !== 3'b101 || redirect_pc !== 32'h0) begin
            failures++;
            $display("FAIL lt_wrap got v=%0b t=%0b m=%0b pc=%h want 1 0 1 00000000", resolve_valid, taken, mispredict, redirect_pc);
        end
        $display("txn lt pc=fffffffc taken=%0b misp=%0b", taken, mispredict);
        // Unsigned borrow set: LTU taken, GEU not taken.
        drive(1, 0, 32'h310, 32'h400, BR_LTU, 1, 2, 0, 32'h310);
        #1; model_step(); @(posedge clk); #1;
        checks++;
        if (taken !== 1'b1 || mispredict !== 1'b1 || redirect_pc !== 32'h400) begin
            failures++; $display("FAIL ltu got t=%0b m=%0b pc=%h want 1 1 00000400", taken, mispredict, redirect_pc);
        end
        drive(1, 0, 32'h310, 32'h400, BR_GEU, 1, 2, 0, 32'h310);
        #1; model_step(); @(posedge clk); #1;
        checks++;
        if (taken !== 1'b0 || mispredict !== 1'b0 || redirect_pc !== 32'h314) begin
            failures++; $display("FAIL geu got t=%0b m=%0b pc=%h want 0 0 00000314", taken, mispredict, redirect_pc);
        end
        $display("txn ltu_geu pc=00000310 taken=%0b misp=%0b", taken, mispredict);
        // BR_NONE predicted taken: alias flush to pc+4, table untouched.
        drive(1, 0, 32'h40, 32'h999, BR_NONE, 0, 0, 1, 32'h40);
        #1; model_step(); @(posedge clk); #1;
        checks++;
        if (taken !== 1'b0 || mispredict !== 1'b1 || redirect_pc !== 32'h44 || predict_taken !== 1'b0) begin
            failures++;
            $display("FAIL none_alias got t=%0b m=%0b pc=%h p=%0b want 0 1 00000044 0", taken, mispredict, redirect_pc, predict_taken);
        end
        $display("txn none_alias pc=00000040 taken=%0b misp=%0b", taken, mispredict);
        checks++;
        if (branch_count !== 32'(exp_bc) || mispredict_count !== 32'(exp_mc)) begin
            failures++;
            $display("FAIL directed_counts got=%0d/%0d want=%0d/%0d", branch_count, mispredict_count, exp_bc, exp_mc);
        end
    endtask

    task automatic test_stall();
        // Would be a taken, mispredicted BR_EQ if it fired.
        drive(1, 1, 32'h200, 32'h500, BR_EQ, 3, 3, 0, 32'h200);
        #1; model_step(); @(posedge clk); #1;
        checks++;
        if ({resolve_valid, taken, mispredict} !== 3'b000 || redirect_pc !== exp_redir) begin
            failures++;
            $display("FAIL stall_result got v=%0b t=%0b m=%0b pc=%h want 0 0 0 %h", resolve_valid, taken, mispredict, redirect_pc, exp_redir);
        end
        checks++;
        if (predict_taken !== model_pred(32'h200) || branch_count !== 32'(exp_bc) || mispredict_count !== 32'(exp_mc)) begin
            failures++;
            $display("FAIL stall_state got p=%0b cnt=%0d/%0d want p=%0b cnt=%0d/%0d", predict_taken, branch_count, mispredict_count, model_pred(32'h200), exp_bc, exp_mc);
        end
        $display("txn stall pc=00000200 valid=%0b", resolve_valid);
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic [31:0] p, a, b, fp;
            branch_op_e  o;
            p  = $urandom & 32'hFFFF_FFFC;
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            fp = ($urandom_range(0, 1) == 0) ? p : ($urandom & 32'hFFFF_FFFC);
            o  = branch_op_e'($urandom_range(0, 7));
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 4) == 0, p, $urandom,
                  o, a, b, $urandom_range(0, 1), fp);
            #1;
            checks++;
            if (predict_taken !== model_pred(fp)) begin
                failures++; $display("FAIL rnd_predict n=%0d got=%0b want=%0b", n, predict_taken, model_pred(fp));
            end
            model_step();
            @(posedge clk); #1;
            checks++;
            if (resolve_valid !== exp_valid || taken !== exp_taken || mispredict !== exp_misp || redirect_pc !== exp_redir) begin
                failures++;
                $display("FAIL rnd_result n=%0d got v=%0b t=%0b m=%0b pc=%h want v=%0b t=%0b m=%0b pc=%h",
                         n, resolve_valid, taken, mispredict, redirect_pc, exp_valid, exp_taken, exp_misp, exp_redir);
            end
            checks++;
            if (branch_count !== 32'(exp_bc) || mispredict_count !== 32'(exp_mc)) begin
                failures++;
                $display("FAIL rnd_counts n=%0d got=%0d/%0d want=%0d/%0d", n, branch_count, mispredict_count, exp_bc, exp_mc);
            end
            $display("txn rnd n=%0d op=%0d pc=%h v=%0b t=%0b m=%0b redir=%h", n, o, p, resolve_valid, taken, mispredict, redirect_pc);
        end
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 32'h200, 32'h180, BR_EQ, 9, 9, 0, 32'h200);
        #1; model_step(); @(posedge clk); #1;
        checks++;
        if (resolve_valid !== 1'b1 || redirect_pc !== exp_redir) begin
            failures++; $display("FAIL mid_pre got v=%0b pc=%h want 1 %h", resolve_valid, redirect_pc, exp_redir);
        end
        #1;
        rst_n = 0;
        valid = 0;
        #1;
        model_reset();
        checks++;
        if ({resolve_valid, taken, mispredict} !== 3'b000 || redirect_pc !== 32'd0 ||
            predict_taken !== 1'b0 || branch_count !== 32'd0 || mispredict_count !== 32'd0) begin
            failures++;
            $display("FAIL mid_reset got v=%0b t=%0b m=%0b pc=%h p=%0b cnt=%0d/%0d want all 0",
                     resolve_valid, taken, mispredict, redirect_pc, predict_taken, branch_count, mispredict_count);
        end
        @(negedge clk);
        rst_n = 1;
        drive(0, 0, 0, 0, BR_NONE, 0, 0, 0, 32'h200);
        #1; model_step(); @(posedge clk); #1;
        checks++;
        if (resolve_valid !== 1'b0 || predict_taken !== model_pred(32'h200)) begin
            failures++; $display("FAIL mid_release got v=%0b p=%0b want 0 %0b", resolve_valid, predict_taken, model_pred(32'h200));
        end
        $display("txn reset_mid v=%0b", resolve_valid);
    endtask

    initial begin
        valid = 0; stall = 0; pc = 0; target = 0; csr = 0; branch_op = 0;
        pred_taken = 0; fetch_pc = 0; op_a = 0; op_b = 0;
        test_reset();
        test_directed();
        test_stall();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
